line_data_memory: RTL and testbench

Off-chip data memory model that sits directly downstream of the data cache and serves whole 256-bit cache lines over the cache's memory port (enable / write / ack handshake). It accepts one line read or line write at a time, holds it for a fixed, parameterised access latency, then commits the write or returns the read data with a single-cycle acknowledge. It also keeps read and write transaction counters for performance checks in simulation.

---
 rtl/line_data_memory.sv | 121 ++++++++++++
 tb/tb_line_data_memory.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_data_memory.sv
// line_data_memory: off-chip line memory behind the data cache.
// Serves one 256-bit line read or write at a time, holds it for LATENCY
// clock edges, then commits the write or returns the read data together
// with a single-cycle ack_o. Read/write completion counters are kept for
// performance checks.
module line_data_memory #(
    parameter int LATENCY    = 10,  // edges from capture to ack_o, 1..255
    parameter int DEPTH_LOG2 = 9    // log2 of the number of 256-bit lines
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    input  logic         enable_i,
    input  logic         write_i,
    output logic         ack_o,
    output logic [255:0] data_o,
    output logic         busy_o,
    output logic [15:0]  rd_cnt_o,
    output logic [15:0]  wr_cnt_o
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    state_t                  state;
    logic [7:0]              lat_cnt;
    logic [DEPTH_LOG2-1:0]   idx_q;
    logic [255:0]            wdata_q;
    logic                    write_q;
    logic                    mem_we;

    logic [255:0]            mem [DEPTH];

    // Offset bits and address bits above the line index are don't-care:
    // out-of-range addresses simply alias onto the array.
    logic unused_addr;
    assign unused_addr = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    // Array write strobe: the captured write commits on the edge that
    // leaves WAIT with the latency counter expired.
    always_comb begin
        // NOTE: default assignment first, so no path leaves mem_we unassigned and no latch is inferred.
        mem_we = 1'b0;
        if ((state == ST_WAIT) && (lat_cnt == 8'd0) && write_q) begin
            mem_we = 1'b1;
        end
    end

    // Line storage: written only through the committed-write strobe.
    always_ff @(posedge clk_i) begin
        // NOTE: the array has no reset; contents deliberately survive rst_i and a reset would make it unmappable to RAM.
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    // Request FSM with registered ack/busy/read data and counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= ST_IDLE;
            lat_cnt  <= 8'd0;
            idx_q    <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            ack_o    <= 1'b0;
            busy_o   <= 1'b0;
            data_o   <= '0;
            rd_cnt_o <= 16'd0;
            wr_cnt_o <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register samples pre-edge values and ordering inside the block does not matter.
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        idx_q   <= addr_i[DEPTH_LOG2+4:5];
                        wdata_q <= data_i;
                        write_q <= write_i;
                        lat_cnt <= LAT_LOAD;
                        busy_o  <= 1'b1;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // Live request inputs are ignored here; only the
                    // captured copies drive the access.
                    if (lat_cnt == 8'd0) begin
                        state <= ST_ACK;
                        ack_o <= 1'b1;
                        if (write_q) begin
                            wr_cnt_o <= wr_cnt_o + 16'd1;
                        end else begin
                            data_o   <= mem[idx_q];
                            rd_cnt_o <= rd_cnt_o + 16'd1;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                ST_ACK: begin
                    // Always one idle edge before the next capture.
                    ack_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    ack_o  <= 1'b0;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_data_memory.sv
// tb_line_data_memory: self-checking bench for line_data_memory.
// A transaction-level reference model (capture edge + fixed latency
// schedule, associative-array memory) is compared against the DUT on
// every falling edge; directed sequences add literal expectations, and a
// LATENCY=1 instance checks the minimum request spacing and aliasing.
module tb_line_data_memory;

    localparam int LAT = 10;

    bit           clk;
    bit           rst;
    logic [31:0]  addr;
    logic [255:0] data;
    bit           enable;
    bit           write;
    logic         ack;
    logic [255:0] dout;
    logic         busy;
    logic [15:0]  rd_cnt;
    logic [15:0]  wr_cnt;

    logic [31:0]  f_addr;
    logic [255:0] f_data;
    bit           f_enable;
    bit           f_write;
    logic         f_ack;
    logic [255:0] f_dout;
    logic         f_busy;
    logic [15:0]  f_rd_cnt;
    logic [15:0]  f_wr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    line_data_memory #(.LATENCY(LAT), .DEPTH_LOG2(9)) u_dut (
        .clk_i(clk), .rst_i(rst), .addr_i(addr), .data_i(data),
        .enable_i(enable), .write_i(write), .ack_o(ack), .data_o(dout),
        .busy_o(busy), .rd_cnt_o(rd_cnt), .wr_cnt_o(wr_cnt)
    );

    line_data_memory #(.LATENCY(1), .DEPTH_LOG2(9)) u_fast (
        .clk_i(clk), .rst_i(rst), .addr_i(f_addr), .data_i(f_data),
        .enable_i(f_enable), .write_i(f_write), .ack_o(f_ack), .data_o(f_dout),
        .busy_o(f_busy), .rd_cnt_o(f_rd_cnt), .wr_cnt_o(f_wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit           m_busy;
    bit           m_ack;
    int           m_edge;
    int           m_cap;
    bit           m_pw;
    int           m_idx;
    logic [255:0] m_pd;
    logic [255:0] m_data;
    logic [15:0]  m_rd;
    logic [15:0]  m_wr;
    logic [255:0] m_mem [int];

    // A request captured at edge E completes at E+LAT and the unit is free
    // again at E+LAT+1; captures only happen while free.
    task model_step();
        if (rst) begin
            m_busy = 0; m_ack = 0; m_edge = 0; m_cap = 0;
            m_data = '0; m_rd = 0; m_wr = 0;
        end else begin
            m_edge++;
            m_ack = 0;
            if (m_busy && m_edge == m_cap + LAT) begin
                m_ack = 1;
                if (m_pw) begin
                    m_mem[m_idx] = m_pd;
                    m_wr++;
                end else begin
                    m_data = m_mem.exists(m_idx) ? m_mem[m_idx] : 'x;
                    m_rd++;
                end
            end else if (m_busy && m_edge == m_cap + LAT + 1) begin
                m_busy = 0;
            end else if (!m_busy && enable) begin
                m_busy = 1;
                m_cap  = m_edge;
                m_pw   = write;
                m_idx  = int'(addr[13:5]);
                m_pd   = data;
            end
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // Cycle compare of every output against the model.
    always @(negedge clk) begin
        check("ack_o", ack, m_ack);
        check("busy_o", busy, m_busy);
        check("data_o", dout, m_data);
        check("rd_cnt_o", rd_cnt, m_rd);
        check("wr_cnt_o", wr_cnt, m_wr);
    end

    // Issue one request from an idle negedge; returns edges from capture
    // to the edge that raised ack_o, and ends one negedge after the ack.
    task automatic do_req(input bit wr, input logic [31:0] a, input logic [255:0] d, output int edges);
        int k;
        enable = 1; write = wr; addr = a; data = d;
        for (k = 1; k < 64; k++) begin
            @(negedge clk);
            if (k == 1) enable = 0;
            if (ack) break;
        end
        edges = k - 1;
        @(negedge clk);
        check("ack_falls", ack, 1'b0);
    endtask

    initial begin
        int           e;
        int           j;
        logic [15:0]  wr_before;
        logic [255:0] d1;

        rst = 1; enable = 0; write = 0; addr = '0; data = '0;
        f_enable = 0; f_write = 0; f_addr = '0; f_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ack", ack, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_data", dout, 256'h0);
        rst = 0;
        @(negedge clk);

        // Write/read round trip
        do_req(1, 32'h0000_0400, {8{32'hA5A5_0001}}, e);
        check("wr_latency", e, LAT);
        check("wr_cnt_1", wr_cnt, 16'd1);
        do_req(0, 32'h0000_0400, 256'h0, e);
        check("rd_latency", e, LAT);
        check("rd_data", dout, {8{32'hA5A5_0001}});
        check("rd_cnt_1", rd_cnt, 16'd1);

        // Pre-fill lines 0..15
        for (int i = 0; i < 16; i++) begin
            do_req(1, 32'(i) << 5, {8{32'hC0DE_0000 + 32'(i)}}, e);
        end
        do_req(1, 32'h0000_0040, 256'h1234, e);
        do_req(1, 32'h0000_00A0, 256'h1, e);

        // Writeback then fill with enable_i held high
        d1 = {8{32'h0BAD_F00D}};
        enable = 1; write = 1; addr = 32'h0000_0020; data = d1;
        for (j = 1; j < 64; j++) begin
            @(negedge clk);
            if (ack) break;
        end
        @(negedge clk);
        check("fill_gap_busy", busy, 1'b0);
        write = 0; addr = 32'h0000_0040;
        @(negedge clk);
        check("fill_capture_busy", busy, 1'b1);
        enable = 0;
        for (j = 3; j < 64; j++) begin
            @(negedge clk);
            if (ack) break;
        end
        check("fill_ack_offset", j, LAT + 2);
        check("fill_data", dout, 256'h1234);
        @(negedge clk);

        // Input changes during WAIT are ignored
        wr_before = m_wr;
        enable = 1; write = 1; addr = 32'd3 << 5; data = 256'hFF;
        @(negedge clk);
        addr = 32'd7 << 5; data = '0; write = 0;
        for (j = 2; j < 64; j++) begin
            @(negedge clk);
            if (ack) break;
        end
        enable = 0;
        check("wait_ignore_latency", j - 1, LAT);
        @(negedge clk);
        check("wait_ignore_wr_cnt", wr_cnt, wr_before + 16'd1);
        do_req(0, 32'd3 << 5, '0, e);
        check("line3_data", dout, 256'hFF);
        do_req(0, 32'd7 << 5, '0, e);
        check("line7_data", dout, {8{32'hC0DE_0007}});

        // Reset mid-write: pending write dropped, older contents kept
        enable = 1; write = 1; addr = 32'd5 << 5; data = 256'h2;
        repeat (5) @(posedge clk);
        enable = 0;
        #2 rst = 1;
        #1;
        check("midrst_ack", ack, 1'b0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_data", dout, 256'h0);
        check("midrst_rd_cnt", rd_cnt, 16'd0);
        check("midrst_wr_cnt", wr_cnt, 16'd0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        do_req(0, 32'd5 << 5, '0, e);
        check("line5_kept", dout, 256'h1);

        // Randomized traffic over lines 0..15 with aliased upper bits
        for (int c = 0; c < 3000; c++) begin
            enable = ($urandom_range(0, 1) == 1);
            write  = ($urandom_range(0, 1) == 1);
            addr   = {$urandom_range(0, 262143), 5'd0, 4'($urandom_range(0, 15)), 5'($urandom_range(0, 31))};
            data   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1;
                #2 rst = 0;
            end
            @(negedge clk);
        end
        enable = 0;
        repeat (LAT + 4) @(negedge clk);

        // LATENCY=1 instance: aliasing and minimum spacing
        d1 = {8{32'h5EED_0001}};
        f_enable = 1; f_write = 1; f_addr = 32'h0000_4020; f_data = d1;
        @(negedge clk);
        f_write = 0; f_addr = 32'h0000_0020; f_data = '0;
        check("fast_wait_ack", f_ack, 1'b0);
        @(negedge clk);
        check("fast_first_ack", f_ack, 1'b1);
        @(negedge clk);
        check("fast_gap_ack", f_ack, 1'b0);
        check("fast_gap_busy", f_busy, 1'b0);
        @(negedge clk);
        check("fast_second_capture", f_busy, 1'b1);
        f_enable = 0;
        @(negedge clk);
        check("fast_second_ack", f_ack, 1'b1);
        check("fast_alias_data", f_dout, d1);
        check("fast_rd_cnt", f_rd_cnt, 16'd1);
        check("fast_wr_cnt", f_wr_cnt, 16'd1);
        @(negedge clk);
        check("fast_idle_busy", f_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
